// File: rtl/hdmi_out_pixel_unpacker.sv
// HDMI output pixel unpacker: pulls packed FIFO words, splits them into pixels
// in step with DE and re-times the syncs for the encoder.
module hdmi_out_pixel_unpacker #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned PIX_WIDTH  = 32,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  vs_in,
   input  logic                  hs_in,
   input  logic                  de_in,
   output logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  empty,
   output logic                  vs_out,
   output logic                  hs_out,
   output logic                  de_out,
   output logic [PIX_WIDTH-1:0]  pix_data,
   output logic                  underflow
);

   localparam int unsigned PPW   = DATA_WIDTH / PIX_WIDTH;
   localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;

   state_t                          state_q, state_d;
   logic                            vs_q;
   logic [RD_LATENCY-1:0]           pipe_q;
   logic [PPW-1:0][PIX_WIDTH-1:0]   cur_q, nxt_q;
   logic                            cur_v_q, nxt_v_q;
   logic [IDX_W-1:0]                idx_q;

   logic vs_rise_c, arrive_c, in_flight_c, last_c, shift_c, rd_issue_c;

   assign vs_rise_c   = vs_in & ~vs_q;
   // pipe_q[RD_LATENCY-1] marks the edge on which the FIFO word is presented
   assign arrive_c    = pipe_q[RD_LATENCY-1];
   assign in_flight_c = rd_en | (|pipe_q);
   assign last_c      = (idx_q == IDX_W'(PPW - 1));
   assign shift_c     = en & de_in & (state_q == ST_RUN) & last_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and read issue; only one read outstanding, never more than two words held
   always_comb begin
      state_d    = state_q;
      rd_issue_c = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (vs_rise_c) state_d = ST_FILL;
            ST_FILL: if (cur_v_q && nxt_v_q) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
         if (state_q != ST_IDLE)
            rd_issue_c = ~empty & ~in_flight_c & ~(cur_v_q & nxt_v_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         vs_out    <= 1'b0;
         hs_out    <= 1'b0;
         de_out    <= 1'b0;
         rd_en     <= 1'b0;
         pipe_q    <= '0;
         cur_q     <= '0;
         nxt_q     <= '0;
         cur_v_q   <= 1'b0;
         nxt_v_q   <= 1'b0;
         idx_q     <= '0;
         pix_data  <= '0;
         underflow <= 1'b0;
      end else begin
         vs_q   <= vs_in;
         vs_out <= vs_in;
         hs_out <= hs_in;
         de_out <= de_in;
         rd_en  <= rd_issue_c;
         pipe_q[0] <= rd_en;
         for (int i = 1; i < int'(RD_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];

         if (!en || state_q == ST_IDLE) begin
            // Returning words are dropped here; underflow only clears while disabled
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
            idx_q   <= '0;
            if (!en) underflow <= 1'b0;
            if (de_in) pix_data <= '0;
         end else begin
            if (de_in) begin
               if (state_q == ST_RUN && cur_v_q) begin
                  pix_data <= cur_q[idx_q];
               end else begin
                  pix_data  <= '0;
                  underflow <= 1'b1;
               end
               if (state_q == ST_RUN) idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
            end
            if (state_q == ST_RUN && vs_rise_c) idx_q <= '0;

            // Slot management: a word retiring and a word arriving may coincide
            if (shift_c) begin
               cur_q   <= nxt_q;
               cur_v_q <= nxt_v_q;
               nxt_v_q <= 1'b0;
               if (arrive_c) begin
                  if (!nxt_v_q) begin
                     cur_q   <= rd_data;
                     cur_v_q <= 1'b1;
                  end else begin
                     nxt_q   <= rd_data;
                     nxt_v_q <= 1'b1;
                  end
               end
            end else if (arrive_c) begin
               if (!cur_v_q) begin
                  cur_q   <= rd_data;
                  cur_v_q <= 1'b1;
               end else begin
                  nxt_q   <= rd_data;
                  nxt_v_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hdmi_out_pixel_unpacker.sv
// Self-checking bench for hdmi_out_pixel_unpacker with a 2-cycle-latency FIFO model.
module tb_hdmi_out_pixel_unpacker;

   localparam int unsigned DW  = 256;
   localparam int unsigned PW  = 32;
   localparam int unsigned PPW = DW / PW;

   logic          clk_tb = 1'b0;
   logic          tb_rst;
   logic          en, vs_in, hs_in, de_in;
   logic          rd_en, empty;
   logic [DW-1:0] rd_data = '0;
   logic          vs_out, hs_out, de_out, underflow;
   logic [PW-1:0] pix_data;

   int checks = 0;
   int errors = 0;

   // FIFO model: word popped at the edge sampling rd_en, presented one edge later
   logic [DW-1:0] mem [0:1023];
   logic [DW-1:0] stage_q = '0;
   int rd_ptr  = 0;
   int wr_lim  = 0;
   int cyc     = 0;
   int rd_cnt  = 0;
   int last_rd = -100;
   int gap_err = 0;

   assign empty = (rd_ptr >= wr_lim);

   hdmi_out_pixel_unpacker #(.DATA_WIDTH(DW), .PIX_WIDTH(PW), .RD_LATENCY(2)) dut (
      .clk(clk_tb), .rst_n(tb_rst), .en(en),
      .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
      .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
      .pix_data(pix_data), .underflow(underflow)
   );

   always #5 clk_tb = ~clk_tb;

   always @(posedge clk_tb) begin
      cyc <= cyc + 1;
      if (rd_en) begin
         rd_cnt <= rd_cnt + 1;
         if (cyc - last_rd < 3) gap_err <= gap_err + 1;
         last_rd <= cyc;
         if (!empty) begin
            stage_q <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
         end
      end
      rd_data <= stage_q;
   end

   // Pixel k of a frame starting at FIFO word 'base'
   function automatic logic [PW-1:0] exp_pix(input int base, input int k);
      logic [DW-1:0] w;
      w = mem[base + k / PPW];
      return w[(k % PPW) * PW +: PW];
   endfunction

   function automatic logic [DW-1:0] make_word(input int n, input bit rnd);
      logic [DW-1:0] w;
      for (int i = 0; i < int'(PPW); i++)
         w[i*PW +: PW] = rnd ? PW'($urandom) : PW'(n * 8 + i);
      return w;
   endfunction

   // Disable, load words, enable and pulse vs, then wait for the buffer to fill
   task automatic start_frame(input int nwords, input bit rnd, output int base);
      en = 1'b0; de_in = 1'b0; vs_in = 1'b0; hs_in = 1'b0;
      repeat (8) @(negedge clk_tb);
      base = rd_ptr;
      for (int n = 0; n < nwords; n++) mem[base + n] = make_word(n, rnd);
      wr_lim = base + nwords;
      en = 1'b1;
      @(negedge clk_tb);
      vs_in = 1'b1;
      @(negedge clk_tb);
      vs_in = 1'b0;
      repeat (14) @(negedge clk_tb);
   endtask

   task automatic test_reset();
      tb_rst = 1'b0; en = 1'b0; vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b1;
      repeat (3) @(negedge clk_tb);
      checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
      checks++; if (vs_out !== 1'b0)   begin errors++; $display("FAIL reset_vs_out: got %b expected 0", vs_out); end
      checks++; if (hs_out !== 1'b0)   begin errors++; $display("FAIL reset_hs_out: got %b expected 0", hs_out); end
      checks++; if (de_out !== 1'b0)   begin errors++; $display("FAIL reset_de_out: got %b expected 0", de_out); end
      checks++; if (pix_data !== '0)   begin errors++; $display("FAIL reset_pix: got %h expected 0", pix_data); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
      vs_in = 1'b0; de_in = 1'b0;
      tb_rst = 1'b1;
      @(negedge clk_tb);
      checks++; if (hs_out !== 1'b1) begin errors++; $display("FAIL sync_delay_hs: got %b expected 1", hs_out); end
      hs_in = 1'b0;
      @(negedge clk_tb);
   endtask

   task automatic test_fill(output int base);
      int r0, g0;
      r0 = rd_cnt; g0 = gap_err;
      start_frame(64, 1'b0, base);
      checks++; if (rd_cnt - r0 != 2) begin errors++; $display("FAIL fill_reads: got %0d expected 2", rd_cnt - r0); end
      checks++; if (gap_err != g0) begin errors++; $display("FAIL fill_read_spacing: got %0d close reads expected 0", gap_err - g0); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL fill_underflow: got %b expected 0", underflow); end
   endtask

   task automatic test_stream(input int base);
      int r0, g0;
      r0 = rd_cnt; g0 = gap_err;
      for (int k = 0; k < 64; k++) begin
         de_in = 1'b1;
         @(negedge clk_tb);
         checks++; if (de_out !== 1'b1) begin errors++; $display("FAIL stream_de_out[%0d]: got %b expected 1", k, de_out); end
         checks++; if (pix_data !== exp_pix(base, k)) begin errors++; $display("FAIL stream_pix[%0d]: got %h expected %h", k, pix_data, exp_pix(base, k)); end
      end
      de_in = 1'b0;
      @(negedge clk_tb);
      checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL stream_de_off: got %b expected 0", de_out); end
      checks++; if (pix_data !== exp_pix(base, 63)) begin errors++; $display("FAIL stream_pix_hold: got %h expected %h", pix_data, exp_pix(base, 63)); end
      repeat (10) @(negedge clk_tb);
      checks++; if (rd_cnt - r0 != 8) begin errors++; $display("FAIL stream_reads: got %0d expected 8", rd_cnt - r0); end
      checks++; if (gap_err != g0) begin errors++; $display("FAIL stream_read_spacing: got %0d close reads expected 0", gap_err - g0); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow: got %b expected 0", underflow); end
   endtask

   task automatic test_underflow(output int base);
      logic [PW-1:0] e;
      start_frame(2, 1'b0, base);
      for (int k = 0; k < 24; k++) begin
         de_in = 1'b1;
         @(negedge clk_tb);
         e = (k < 16) ? exp_pix(base, k) : '0;
         checks++; if (pix_data !== e) begin errors++; $display("FAIL uflow_pix[%0d]: got %h expected %h", k, pix_data, e); end
         checks++; if (underflow !== (k >= 16)) begin errors++; $display("FAIL uflow_flag[%0d]: got %b expected %b", k, underflow, (k >= 16)); end
      end
      de_in = 1'b0;
      repeat (3) @(negedge clk_tb);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky: got %b expected 1", underflow); end
   endtask

   task automatic test_en_drop(input int base);
      bit seen;
      for (int n = 2; n < 12; n++) mem[base + n] = make_word(n, 1'b0);
      wr_lim = base + 12;
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk_tb);
         if (rd_en) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL en_drop_read_wait: got no rd_en expected rd_en within 10 cycles"); end
      en = 1'b0;
      @(negedge clk_tb);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL en_drop_uflow_clear: got %b expected 0", underflow); end
      repeat (8) @(negedge clk_tb);
      en = 1'b1;
      @(negedge clk_tb);
      vs_in = 1'b1;
      @(negedge clk_tb);
      vs_in = 1'b0;
      repeat (14) @(negedge clk_tb);
      // word base+2 was in flight when disabled and must not appear
      for (int k = 0; k < 16; k++) begin
         de_in = 1'b1;
         @(negedge clk_tb);
         checks++; if (pix_data !== exp_pix(base, 24 + k)) begin errors++; $display("FAIL en_drop_restart[%0d]: got %h expected %h", k, pix_data, exp_pix(base, 24 + k)); end
      end
      de_in = 1'b0;
      @(negedge clk_tb);
   endtask

   task automatic test_random_gaps();
      int base, k;
      logic d, h;
      logic [PW-1:0] last;
      start_frame(20, 1'b1, base);
      k = 0; last = '0;
      for (int c = 0; c < 80; c++) begin
         d = (c == 0) ? 1'b1 : 1'($urandom % 2);
         h = 1'($urandom % 2);
         de_in = d; hs_in = h;
         @(negedge clk_tb);
         checks++; if (hs_out !== h) begin errors++; $display("FAIL gaps_hs[%0d]: got %b expected %b", c, hs_out, h); end
         checks++; if (de_out !== d) begin errors++; $display("FAIL gaps_de[%0d]: got %b expected %b", c, de_out, d); end
         if (d) begin
            last = exp_pix(base, k);
            k++;
         end
         checks++; if (pix_data !== last) begin errors++; $display("FAIL gaps_pix[%0d]: got %h expected %h", c, pix_data, last); end
      end
      de_in = 1'b0; hs_in = 1'b0;
      @(negedge clk_tb);
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL gaps_underflow: got %b expected 0", underflow); end
   endtask

   task automatic test_async_reset();
      int base, base2, r0;
      start_frame(20, 1'b1, base);
      for (int k = 0; k < 5; k++) begin
         de_in = 1'b1;
         @(negedge clk_tb);
         checks++; if (pix_data !== exp_pix(base, k)) begin errors++; $display("FAIL areset_pre_pix[%0d]: got %h expected %h", k, pix_data, exp_pix(base, k)); end
      end
      @(posedge clk_tb);
      #3 tb_rst = 1'b0;
      #1;
      checks++; if (pix_data !== '0) begin errors++; $display("FAIL areset_pix: got %h expected 0", pix_data); end
      checks++; if (de_out !== 1'b0) begin errors++; $display("FAIL areset_de_out: got %b expected 0", de_out); end
      @(negedge clk_tb);
      tb_rst = 1'b1;
      r0 = rd_cnt;
      for (int c = 0; c < 12; c++) begin
         de_in = 1'(c % 2);
         @(negedge clk_tb);
      end
      de_in = 1'b0;
      checks++; if (rd_cnt != r0) begin errors++; $display("FAIL areset_no_read: got %0d reads expected 0", rd_cnt - r0); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL areset_idle_uflow: got %b expected 0", underflow); end
      base2 = rd_ptr;
      vs_in = 1'b1;
      @(negedge clk_tb);
      vs_in = 1'b0;
      repeat (14) @(negedge clk_tb);
      checks++; if (rd_cnt - r0 != 2) begin errors++; $display("FAIL areset_refill: got %0d reads expected 2", rd_cnt - r0); end
      for (int k = 0; k < 8; k++) begin
         de_in = 1'b1;
         @(negedge clk_tb);
         checks++; if (pix_data !== exp_pix(base2, k)) begin errors++; $display("FAIL areset_post_pix[%0d]: got %h expected %h", k, pix_data, exp_pix(base2, k)); end
      end
      de_in = 1'b0;
      @(negedge clk_tb);
   endtask

   initial begin
      int base;
      test_reset();
      test_fill(base);
      test_stream(base);
      test_underflow(base);
      test_en_drop(base);
      test_random_gaps();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
